// File: rtl/addr_gen_if.sv
// Bus bundle for addr_gen: op/config inputs from the master, address/stack status back.
interface addr_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SW  = (NSRC > 2) ? $clog2(NSRC) : 1;
    localparam int unsigned SPW = $clog2(DEPTH + 1);

    logic                    WEN;
    logic [2:0]              op;
    logic [SW-1:0]           selSrc;
    logic [NSRC*WIDTH-1:0]   SrcIn;
    logic [WIDTH-1:0]        Stride;
    logic [WIDTH-1:0]        Base;
    logic [WIDTH-1:0]        Limit;
    logic [WIDTH-1:0]        dout;
    logic                    wrap;
    logic                    err;
    logic [SPW-1:0]          sp;
    logic                    full;
    logic                    empty;

    modport master (
        output WEN, op, selSrc, SrcIn, Stride, Base, Limit,
        input  dout, wrap, err, sp, full, empty
    );

    modport slave (
        input  WEN, op, selSrc, SrcIn, Stride, Base, Limit,
        output dout, wrap, err, sp, full, empty
    );
endinterface

// File: rtl/addr_gen.sv
// Windowed address generator: load/inc/dec within [Base, Limit] with wrap,
// plus a small LIFO save stack for the current address.
module addr_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    addr_gen_if.slave   bus
);
    localparam int unsigned SW  = (NSRC > 2) ? $clog2(NSRC) : 1;
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SW:0]    NSRC_W = (SW + 1)'(NSRC);
    localparam logic [SPW-1:0] SP_ONE = SPW'(1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_INC   = 3'b010,
        OP_DEC   = 3'b011,
        OP_PUSH  = 3'b100,
        OP_POP   = 3'b101,
        OP_CLEAR = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SPW-1:0]   sp_q,   sp_d;
    logic             wrap_q, wrap_d;
    logic             err_q,  err_d;
    logic             push_c;
    logic             full_c, empty_c;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] src_c   [NSRC];
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   dec_floor_c;
    logic             bad_win_c;

    // Unpack the flat source bus into an indexable array
    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src_c[k] = bus.SrcIn[k*WIDTH +: WIDTH];
        end
    end

    assign full_c      = (sp_q == SP_MAX);
    assign empty_c     = (sp_q == '0);
    assign sum_c       = {1'b0, dout_q} + {1'b0, bus.Stride};
    assign dec_floor_c = {1'b0, bus.Base} + {1'b0, bus.Stride};
    assign bad_win_c   = (bus.Base > bus.Limit);

    // Next-state decode; wrap/err default low so they pulse for one cycle
    always_comb begin
        dout_d = dout_q;
        sp_d   = sp_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        push_c = 1'b0;
        if (bus.WEN) begin
            case (op_e'(bus.op))
                OP_HOLD: ;
                OP_LOAD: begin
                    if ({1'b0, bus.selSrc} < NSRC_W) begin
                        dout_d = src_c[bus.selSrc];
                    end else begin
                        dout_d = src_c[0];
                        err_d  = 1'b1;
                    end
                end
                OP_INC: begin
                    if (bad_win_c) begin
                        dout_d = bus.Base;
                        err_d  = 1'b1;
                    end else if (sum_c > {1'b0, bus.Limit}) begin
                        dout_d = bus.Base;
                        wrap_d = 1'b1;
                    end else begin
                        dout_d = sum_c[WIDTH-1:0];
                    end
                end
                OP_DEC: begin
                    if (bad_win_c) begin
                        dout_d = bus.Base;
                        err_d  = 1'b1;
                    end else if ({1'b0, dout_q} < dec_floor_c) begin
                        dout_d = bus.Limit;
                        wrap_d = 1'b1;
                    end else begin
                        dout_d = dout_q - bus.Stride;
                    end
                end
                OP_PUSH: begin
                    if (full_c) begin
                        err_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                        sp_d   = sp_q + SP_ONE;
                    end
                end
                OP_POP: begin
                    if (empty_c) begin
                        err_d = 1'b1;
                    end else begin
                        dout_d = stack_q[AW'(sp_q - SP_ONE)];
                        sp_d   = sp_q - SP_ONE;
                    end
                end
                OP_CLEAR: dout_d = bus.Base;
                default:  err_d  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dout_q <= '0;
            sp_q   <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sp_q   <= sp_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // Stack storage carries no reset; occupancy alone defines what is visible
    always_ff @(posedge Clk) begin
        if (push_c && !Rst) begin
            stack_q[AW'(sp_q)] <= dout_q;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;
    assign bus.sp    = sp_q;
    assign bus.full  = full_c;
    assign bus.empty = empty_c;
endmodule
